// File: rtl/demux_deser16.sv
// Serial-to-parallel deserializer: steers each accepted bit into a collect buffer
// at the running select index and hands off completed words over valid/ready.
module demux_deser16 #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_first,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             frame_err
);

    logic [WIDTH-1:0] collect;
    logic [WIDTH-1:0] collect_nxt;
    logic [WIDTH-1:0] word_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             valid_nxt;
    logic             ferr_nxt;
    logic             last;
    logic             accept;
    logic             handoff;

    // Next-state: the final bit of a word stalls only while the previous word is unconsumed.
    always_comb begin
        last        = (sel == SEL_W'(WIDTH - 1));
        in_ready    = !(last && out_valid && !out_ready);
        accept      = in_valid && in_ready;
        handoff     = out_valid && out_ready;
        sel_nxt     = sel;
        collect_nxt = collect;
        word_nxt    = out_word;
        valid_nxt   = out_valid;
        ferr_nxt    = 1'b0;

        if (handoff) begin
            valid_nxt = 1'b0;
        end

        if (accept) begin
            if (in_first) begin
                // Realign: any partial word is dropped and the bit lands at index 0.
                collect_nxt    = '0;
                collect_nxt[0] = in_bit;
                sel_nxt        = SEL_W'(1);
                ferr_nxt       = (sel != '0);
            end else begin
                collect_nxt[sel] = in_bit;
                sel_nxt          = sel + SEL_W'(1);
                if (last) begin
                    word_nxt  = {in_bit, collect[WIDTH-2:0]};
                    valid_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel       <= '0;
            collect   <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sel       <= sel_nxt;
            collect   <= collect_nxt;
            out_word  <= word_nxt;
            out_valid <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

endmodule
